up3_mem_arbiter: RTL and testbench
==================================

// Module: up3_mem_arbiter
// PURPOSE
//  Shares the single-port up3ram between the up3 CPU (fetch/execute via the address mux) and an external
//  loader/debug port. Arbitrates per cycle and returns read data one cycle later with a valid tag.
//  Supports an external bus lock for burst program loading, with a timeout.
//  Sits between up3_cu's memory signals (mar/ac/store_mem) and the RAM instance.
// PARAMETERS
//  AW        8   RAM address width
//  DW        8   RAM data width
//  LOCK_MAX  16  max consecutive locked cycles before forced release (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  cpu_req     in   1   CPU requests an access this cycle
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  CPU address (mar)
//  cpu_wdata   in   DW  CPU write data (ac)
//  cpu_gnt     out  1   CPU access issued to RAM this cycle
//  cpu_rvalid  out  1   cpu_rdata valid (read granted previous cycle)
//  cpu_rdata   out  DW  read data
//  ext_req/ext_we/ext_addr/ext_wdata  in  1/1/AW/DW  external requester, same meaning
//  ext_lock    in   1   hold bus for ext while asserted
//  ext_gnt/ext_rvalid/ext_rdata       out 1/1/DW   external grant/return, same meaning
//  lock_err    out  1   one-cycle pulse: lock forcibly released by timeout
//  ram_addr    out  AW  to RAM address
//  ram_data    out  DW  to RAM write data
//  ram_wren    out  1   to RAM write enable
//  ram_q       in   DW  RAM read data (valid cycle after address)
// BEHAVIOUR
//  - Reset: state=S_IDLE, last_winner=EXT, lock_cnt=0, lock_blk=0; all gnt/rvalid/lock_err=0; ram_wren=0.
//  - Grants combinational from req + registered state; at most one gnt high per cycle. Granted requester's
//    addr/wdata/we drive ram_*; no grant -> ram_wren=0, ram_addr=cpu_addr, ram_data=cpu_wdata.
//  - Read latency 1: rvalid registered = gnt & ~we of previous cycle; *_rdata = ram_q (both ports).
//  - Contention (both req, state not S_LOCK): round-robin, winner = requester not last_winner; last_winner
//    updates only on contended cycles. Single requester always wins.
//  - FSM (registered, reflects current cycle's grant):
//    S_IDLE/S_CPU/S_EXT -> S_LOCK if ext_gnt & ext_lock & ~lock_blk; else S_CPU/S_EXT/S_IDLE per grant.
//    S_LOCK: ext_gnt=ext_req, cpu_gnt=0; lock_cnt++ each cycle; exit to S_IDLE when ext_lock=0.
//    lock_cnt==LOCK_MAX-1 -> S_IDLE, lock_err pulse, lock_blk=1; lock_blk clears when ext_lock=0.
//    lock_cnt clears on leaving S_LOCK.
//  - lock_blk=1: ext_lock ignored, normal round-robin applies.
//  - Reset mid-access: in-flight rvalid suppressed (0 in cycle after reset).
//  - Write and read never overlap; a write grant produces no rvalid.
// CONFIGURATION
//  UP3_ARB_STATS_EN defined: adds outputs cpu_gnt_cnt[15:0], ext_gnt_cnt[15:0], conflict_cnt[15:0];
//   saturating counters of grants and contended cycles, cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  up3_pkg: arb_state_t {S_IDLE,S_CPU,S_EXT,S_LOCK}, req_id_t {REQ_CPU,REQ_EXT}.
//  Sub-module up3_lock_timer: lock_cnt, timeout compare, lock_err, lock_blk.
// TESTING
//  1 CPU-only read addr 8'h10 (RAM=8'hA5) -> cpu_gnt same cycle, cpu_rvalid=1, cpu_rdata=A5 next cycle.
//  2 Both req every cycle after reset -> CPU,EXT,CPU,EXT alternation; conflict_cnt counts each cycle.
//  3 ext write 8'h3C to 8'h20 while cpu idle -> ram_wren=1 one cycle, no ext_rvalid; CPU read of 20 returns 3C.
//  4 ext_lock held 5 cycles, cpu_req high -> cpu_gnt=0 for 5 cycles, then CPU granted after ext_lock drops.
//  5 ext_lock held 40 cycles, LOCK_MAX=16 -> lock_err at locked cycle 16, then round-robin resumes.
//  6 reset asserted in cycle after a CPU read grant -> cpu_rvalid=0, state S_IDLE, all grants 0.

Source files
------------

// File: rtl/up3_pkg.sv
// Shared types for the up3 memory arbiter: FSM states, requester ids, stats helpers.
package up3_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_EXT  = 2'd2,
    S_LOCK = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_t;

  localparam int unsigned STAT_W = 16;

  // Saturating increment for the optional statistics counters
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/up3_mem_arbiter_if.sv
// Request/grant/return bus between the two requesters, the arbiter and the up3ram.
interface up3_mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_lock;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          lock_err;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  ram_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output lock_err,
    output ram_addr, ram_data, ram_wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output ram_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  lock_err,
    input  ram_addr, ram_data, ram_wren
  );
endinterface

// File: rtl/up3_lock_timer.sv
// Bounds how long the external port may hold the bus lock; blocks re-locking after a timeout.
module up3_lock_timer #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_lock,
  input  logic ext_lock,
  output logic timeout_c,
  output logic lock_err,
  output logic lock_blk
);
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] lock_cnt;

  assign timeout_c = in_lock & ext_lock & (lock_cnt == CW'(LOCK_MAX - 1));

  // Count consecutive locked cycles; clear whenever the lock is left
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (in_lock && ext_lock && !timeout_c) begin
      lock_cnt <= lock_cnt + CW'(1);
    end else begin
      lock_cnt <= '0;
    end
  end

  // Timeout pulse and lock block, held until the requester drops ext_lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_err <= 1'b0;
      lock_blk <= 1'b0;
    end else begin
      lock_err <= timeout_c;
      if (timeout_c) begin
        lock_blk <= 1'b1;
      end else if (!ext_lock) begin
        lock_blk <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/up3_mem_arbiter.sv
// up3ram arbiter: CPU vs external loader, round-robin with external bus lock and timeout.
// Build option: define UP3_ARB_STATS_EN to add saturating grant/conflict counters.
module up3_mem_arbiter
  import up3_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  up3_mem_arbiter_if.slave bus
`ifdef UP3_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cpu_gnt_cnt,
  output logic [STAT_W-1:0] ext_gnt_cnt,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);
  arb_state_t    state, next_state;
  req_id_t       last_winner, next_winner;
  logic          cpu_gnt_c, ext_gnt_c, contend_c;
  logic          cpu_rv_q, ext_rv_q;
  logic          timeout_c, lock_blk, lock_err;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] data_c;
  logic          wren_c;

  up3_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
    .clk       (clk),
    .reset     (reset),
    .in_lock   (state == S_LOCK),
    .ext_lock  (bus.ext_lock),
    .timeout_c (timeout_c),
    .lock_err  (lock_err),
    .lock_blk  (lock_blk)
  );

  // State and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_winner <= REQ_EXT;
    end else begin
      state       <= next_state;
      last_winner <= next_winner;
    end
  end

  // Grant decision and next state; no grants while reset is asserted
  always_comb begin
    cpu_gnt_c   = 1'b0;
    ext_gnt_c   = 1'b0;
    contend_c   = 1'b0;
    next_winner = last_winner;
    next_state  = state;
    if (!reset) begin
      if (state == S_LOCK) begin
        ext_gnt_c = bus.ext_req;
      end else if (bus.cpu_req && bus.ext_req) begin
        contend_c = 1'b1;
        if (last_winner == REQ_EXT) begin
          cpu_gnt_c   = 1'b1;
          next_winner = REQ_CPU;
        end else begin
          ext_gnt_c   = 1'b1;
          next_winner = REQ_EXT;
        end
      end else begin
        cpu_gnt_c = bus.cpu_req;
        ext_gnt_c = bus.ext_req;
      end
    end
    if (state == S_LOCK) begin
      next_state = (timeout_c || !bus.ext_lock) ? S_IDLE : S_LOCK;
    end else if (ext_gnt_c && bus.ext_lock && !lock_blk) begin
      next_state = S_LOCK;
    end else if (cpu_gnt_c) begin
      next_state = S_CPU;
    end else if (ext_gnt_c) begin
      next_state = S_EXT;
    end else begin
      next_state = S_IDLE;
    end
  end

  // RAM port mux: winner drives the RAM, CPU signals park on it when idle
  always_comb begin
    addr_c = bus.cpu_addr;
    data_c = bus.cpu_wdata;
    wren_c = 1'b0;
    if (ext_gnt_c) begin
      addr_c = bus.ext_addr;
      data_c = bus.ext_wdata;
      wren_c = bus.ext_we;
    end else if (cpu_gnt_c) begin
      wren_c = bus.cpu_we;
    end
  end

  // Read-return tags, one cycle behind the read grant
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rv_q <= 1'b0;
      ext_rv_q <= 1'b0;
    end else begin
      cpu_rv_q <= cpu_gnt_c & ~bus.cpu_we;
      ext_rv_q <= ext_gnt_c & ~bus.ext_we;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.ext_gnt    = ext_gnt_c;
  assign bus.cpu_rvalid = cpu_rv_q & ~reset;
  assign bus.ext_rvalid = ext_rv_q & ~reset;
  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.ext_rdata  = bus.ram_q;
  assign bus.lock_err   = lock_err;
  assign bus.ram_addr   = addr_c;
  assign bus.ram_data   = data_c;
  assign bus.ram_wren   = wren_c;

`ifdef UP3_ARB_STATS_EN
  // Saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt_cnt  <= '0;
      ext_gnt_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cpu_gnt_c) cpu_gnt_cnt  <= sat_inc(cpu_gnt_cnt);
      if (ext_gnt_c) ext_gnt_cnt  <= sat_inc(ext_gnt_cnt);
      if (contend_c) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_up3_mem_arbiter.sv
// Directed bench for up3_mem_arbiter with a read-data scoreboard and a behavioural up3ram.
module tb_up3_mem_arbiter;
  import up3_pkg::*;

  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned LOCK_MAX = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  up3_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef UP3_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, ext_gnt_cnt, conflict_cnt;
`endif

  up3_mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UP3_ARB_STATS_EN
    ,
    .cpu_gnt_cnt  (cpu_gnt_cnt),
    .ext_gnt_cnt  (ext_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  logic [DW-1:0] ram_mem   [256];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] ext_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural single-port RAM, registered read
  always @(posedge clk) begin
    if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= ram_mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected read data whenever a return is tagged valid
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(1), 32'(0));
        else chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (bus.ext_rvalid) begin
        if (ext_q.size() == 0) chk("ext_rvalid_unexpected", 32'(1), 32'(0));
        else chk("ext_rdata", 32'(bus.ext_rdata), 32'(ext_q.pop_front()));
      end
    end
  end

  // One bus cycle: drive after the edge, check grants/RAM controls, record expectations
  task automatic cyc(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                     input logic [7:0] c_wd, input logic e_req, input logic e_we,
                     input logic [7:0] e_addr, input logic [7:0] e_wd, input logic e_lock,
                     input logic exp_c, input logic exp_e, input string tag);
    @(posedge clk);
    #1;
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.ext_req   = e_req;
    bus.ext_we    = e_we;
    bus.ext_addr  = e_addr;
    bus.ext_wdata = e_wd;
    bus.ext_lock  = e_lock;
    #1;
    chk({tag, "_cpu_gnt"}, 32'(bus.cpu_gnt), 32'(exp_c));
    chk({tag, "_ext_gnt"}, 32'(bus.ext_gnt), 32'(exp_e));
    chk({tag, "_ram_wren"}, 32'(bus.ram_wren), 32'((exp_c & c_we) | (exp_e & e_we)));
    if (exp_e) chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(e_addr));
    else       chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(c_addr));
    if (exp_c) begin
      if (c_we) model_mem[c_addr] = c_wd;
      else cpu_q.push_back(model_mem[c_addr]);
    end
    if (exp_e) begin
      if (e_we) model_mem[e_addr] = e_wd;
      else ext_q.push_back(model_mem[e_addr]);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, "idle");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.ext_lock = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_q.delete();
    ext_q.delete();
  endtask

  task automatic drain(input string tag);
    idle();
    idle();
    chk({tag, "_cpu_q_empty"}, 32'(cpu_q.size()), 32'(0));
    chk({tag, "_ext_q_empty"}, 32'(ext_q.size()), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram_mem[a]   = 8'(a) ^ 8'h5A;
      model_mem[a] = 8'(a) ^ 8'h5A;
    end
    ram_mem[8'h10]   = 8'hA5;
    model_mem[8'h10] = 8'hA5;

    // Reset state
    do_reset();
    #1;
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'(0));
    chk("rst_ext_gnt", 32'(bus.ext_gnt), 32'(0));
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
    chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'(0));
    chk("rst_lock_err", 32'(bus.lock_err), 32'(0));
    chk("rst_ram_wren", 32'(bus.ram_wren), 32'(0));

    // 1: CPU-only read returns A5 next cycle
    cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, "t1");
    idle();
    chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(1));
    chk("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'(8'hA5));
    drain("t1");

    // 2: permanent contention alternates CPU, EXT, ...
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 8'(8'h30 + i), 8'h00, 1, 0, 8'(8'h50 + i), 8'h00, 0,
          (i % 2) == 0, (i % 2) == 1, "t2");
`ifdef UP3_ARB_STATS_EN
    idle();
    chk("t2_conflict_cnt", 32'(conflict_cnt), 32'(8));
    chk("t2_cpu_gnt_cnt", 32'(cpu_gnt_cnt), 32'(4));
`endif
    drain("t2");

    // 3: external write, no rvalid, then CPU reads it back
    do_reset();
    cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 0, 1, "t3_wr");
    idle();
    chk("t3_no_ext_rvalid", 32'(bus.ext_rvalid), 32'(0));
    cyc(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, "t3_rd");
    idle();
    chk("t3_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(1));
    chk("t3_cpu_rdata", 32'(bus.cpu_rdata), 32'(8'h3C));
    drain("t3");

    // 4: short lock holds off the CPU until released
    do_reset();
    cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00, 1, 0, 1, "t4_take");
    for (int i = 1; i < 5; i++)
      cyc(1, 0, 8'(8'h70 + i), 8'h00, 1, 0, 8'(8'h60 + i), 8'h00, 1, 0, 1, "t4_held");
    cyc(1, 0, 8'h75, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, "t4_drop");
    cyc(1, 0, 8'h76, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, "t4_cpu");
    drain("t4");

    // 5: lock held beyond LOCK_MAX times out, then round-robin resumes
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(i != 0, 0, 8'(i), 8'h00, 1, 0, 8'(8'h80 + i), 8'h00, 1,
          (i >= 17) && (((i - 17) % 2) == 0),
          (i <= 16) || (((i - 17) % 2) == 1), "t5");
      chk("t5_lock_err", 32'(bus.lock_err), 32'(i == 17));
    end
    drain("t5");

    // 6: reset right after a CPU read grant kills the return
    do_reset();
    cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, "t6_rd");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_cpu_rvalid_in_rst", 32'(bus.cpu_rvalid), 32'(0));
    chk("t6_cpu_gnt_in_rst", 32'(bus.cpu_gnt), 32'(0));
    @(posedge clk);
    #2;
    chk("t6_state", 32'(dut.state), 32'(S_IDLE));
    chk("t6_cpu_rvalid_after", 32'(bus.cpu_rvalid), 32'(0));
    chk("t6_cpu_gnt_after", 32'(bus.cpu_gnt), 32'(0));
    chk("t6_ext_gnt_after", 32'(bus.ext_gnt), 32'(0));
    bus.cpu_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_q.delete();
    ext_q.delete();
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
